instr_fetch_unit: RTL and testbench

//  Fetch stage between the synchronous instruction memory and the decoder/control path.

---
 rtl/ifu_pkg.sv | 19 +
 rtl/ifu_fifo.sv | 59 +++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - widths, reset PC, FSM states and FIFO entry type for the fetch unit
package ifu_pkg;

   localparam int ADDR_W = 12;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 12'h000;

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2
   } ifu_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// rtl/ifu_fifo.sv - synchronous FIFO of PC-tagged instruction words with flush and level
// Head is read straight from the registered array, so a written word is visible next cycle.
module ifu_fifo
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   input  logic                   wr_en_i,
   input  ifu_entry_t             wr_data_i,
   input  logic                   rd_en_i,
   output ifu_entry_t             rd_data_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   ifu_entry_t        mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              wr_ok, rd_ok;

   assign rd_ok = rd_en_i & (count_q != '0);
   assign wr_ok = wr_en_i & ((count_q != FULL_CNT) | rd_ok);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;
   assign empty_o   = (count_q == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch PC, sequential imem reads, tagged word buffer, redirect flush
// IFU_BYPASS_EN: a live response reaching an empty FIFO is presented to the decoder the same cycle.
module instr_fetch_unit
   import ifu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   output logic [ADDR_W-1:0]      imem_addr_o,
   output logic                   imem_rd_o,
   input  logic [DATA_W-1:0]      imem_q_i,
   output logic [DATA_W-1:0]      instr_out_o,
   output logic [ADDR_W-1:0]      instr_pc_o,
   output logic                   instr_valid_o,
   input  logic                   instr_ready_i,
   input  logic                   redirect_i,
   input  logic [ADDR_W-1:0]      redirect_addr_i,
   input  logic                   halt_i,
   output logic [$clog2(DEPTH):0] fifo_level_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

   ifu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d, resp_pc_q;
   logic              inflight_q, dead_q;
   logic [CW-1:0]     count;
   logic [CW:0]       occ;
   logic              fifo_empty, fifo_wr, fifo_rd;
   ifu_entry_t        head, resp, out_entry;
   logic              redirect_live, live_resp, head_valid, bypass, pop, issue;

   assign redirect_live = redirect_i & (state_q != S_BOOT);
   assign live_resp     = inflight_q & ~dead_q;
   assign resp          = {resp_pc_q, imem_q_i};

`ifdef IFU_BYPASS_EN
   assign bypass    = live_resp & fifo_empty;
   assign out_entry = fifo_empty ? resp : head;
`else
   assign bypass    = 1'b0;
   assign out_entry = head;
`endif

   assign head_valid    = ~fifo_empty | bypass;
   assign instr_valid_o = head_valid & ~redirect_live;
   assign pop           = instr_valid_o & instr_ready_i;
   assign fifo_rd       = pop & ~fifo_empty;
   assign fifo_wr       = live_resp & ~(bypass & pop);

   // Buffered plus in-flight words may never exceed DEPTH; a same-cycle pop frees one slot.
   assign occ   = {1'b0, count} + {{CW{1'b0}}, inflight_q};
   assign issue = (state_q == S_FETCH) &
                  ((occ < DEPTH_OCC) | ((occ == DEPTH_OCC) & pop));

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         S_BOOT:  state_d = halt_i ? S_HOLD : S_FETCH;
         S_FETCH: if (halt_i) state_d = S_HOLD;
         S_HOLD:  if (!halt_i) state_d = S_FETCH;
         default: state_d = S_BOOT;
      endcase
      if (issue) pc_d = pc_q + 1'b1;
      if (redirect_live) pc_d = redirect_addr_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_BOOT;
         pc_q       <= RESET_PC;
         resp_pc_q  <= '0;
         inflight_q <= 1'b0;
         dead_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         inflight_q <= issue;
         // A read issued alongside a redirect returns stale code and must be dropped.
         dead_q     <= issue & redirect_live;
         if (issue) resp_pc_q <= pc_q;
      end
   end

   ifu_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .flush_i  (redirect_live),
      .wr_en_i  (fifo_wr),
      .wr_data_i(resp),
      .rd_en_i  (fifo_rd),
      .rd_data_o(head),
      .count_o  (count),
      .empty_o  (fifo_empty)
   );

   assign imem_addr_o  = pc_q;
   assign imem_rd_o    = issue;
   assign instr_out_o  = instr_valid_o ? out_entry.instr : '0;
   assign instr_pc_o   = instr_valid_o ? out_entry.pc : '0;
   assign fifo_level_o = count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   localparam int DEPTH = 4;
`ifdef IFU_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif
   localparam int FIRST = 1 + LAT;
   localparam int LATR  = LAT + 1;
   localparam logic [11:0] RESET_PC = 12'h000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] imem_addr;
   logic        imem_rd;
   logic [15:0] imem_q = 16'h0000;
   logic [15:0] instr_out;
   logic [11:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect;
   logic [11:0] redirect_addr;
   logic        halt;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [11:0] pc;
      int          icyc;
   } ent_t;
   ent_t mq[$];

   instr_fetch_unit #(.DEPTH(DEPTH)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .imem_addr_o    (imem_addr),
      .imem_rd_o      (imem_rd),
      .imem_q_i       (imem_q),
      .instr_out_o    (instr_out),
      .instr_pc_o     (instr_pc),
      .instr_valid_o  (instr_valid),
      .instr_ready_i  (instr_ready),
      .redirect_i     (redirect),
      .redirect_addr_i(redirect_addr),
      .halt_i         (halt),
      .fifo_level_o   (fifo_level)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] word_of(input logic [11:0] a);
      return 16'hA000 + {4'h0, a};
   endfunction

   always @(posedge clk) begin
      if (imem_rd) imem_q <= word_of(imem_addr);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic rdy, input logic hlt, input logic rdr, input logic [11:0] ra);
      @(posedge clk);
      #1;
      instr_ready   = rdy;
      halt          = hlt;
      redirect      = rdr;
      redirect_addr = ra;
      @(negedge clk);
   endtask

   // Reference model: every issued PC is queued with its issue cycle; words leave in order.
   initial begin : compare
      int          cyc_n, n2, nl, occ;
      logic        prev_halt, redir, exp_valid, pop, fetch, exp_rd;
      logic [11:0] mpc;
      cyc_n = 0;
      prev_halt = 1'b0;
      mpc = RESET_PC;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_rd", 32'(imem_rd), 0);
            chk("rst_valid", 32'(instr_valid), 0);
            chk("rst_level", 32'(fifo_level), 0);
            chk("rst_instr", 32'(instr_out), 0);
            chk("rst_pc", 32'(instr_pc), 0);
            chk("rst_addr", 32'(imem_addr), 32'(RESET_PC));
            mq.delete();
            cyc_n = 0;
            prev_halt = 1'b0;
            mpc = RESET_PC;
         end else begin
            n2 = 0;
            nl = 0;
            foreach (mq[i]) begin
               if (mq[i].icyc <= cyc_n - 2) n2++;
               if (mq[i].icyc <= cyc_n - LAT) nl++;
            end
            redir = redirect && (cyc_n != 0);
            exp_valid = (nl > 0) && !redir;
            chk("m_valid", 32'(instr_valid), 32'(exp_valid));
            chk("m_level", 32'(fifo_level), n2);
            if (exp_valid) begin
               chk("m_pc", 32'(instr_pc), 32'(mq[0].pc));
               chk("m_instr", 32'(instr_out), 32'(word_of(mq[0].pc)));
            end
            pop = exp_valid && instr_ready;
            fetch = (cyc_n >= 1) && !prev_halt;
            occ = mq.size();
            exp_rd = fetch && ((occ < DEPTH) || ((occ == DEPTH) && pop));
            chk("m_rd", 32'(imem_rd), 32'(exp_rd));
            if (exp_rd) chk("m_addr", 32'(imem_addr), 32'(mpc));
            if (pop) void'(mq.pop_front());
            if (exp_rd) begin
               mq.push_back('{pc: mpc, icyc: cyc_n});
               mpc = mpc + 12'h001;
            end
            if (redir) begin
               mq.delete();
               mpc = redirect_addr;
            end
            prev_halt = halt;
            cyc_n++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1);
   end

   initial begin : stim
      logic [11:0] wrap_pc [4];
      logic        hlt;
      wrap_pc = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      rst_n = 1'b0;
      halt = 1'b0;
      instr_ready = 1'b1;
      redirect = 1'b0;
      redirect_addr = 12'h000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_rd", 32'(imem_rd), 0);
      chk("boot_valid", 32'(instr_valid), 0);

      // Streaming from reset
      for (int c = 1; c <= 8; c++) begin
         cyc(1'b1, 1'b0, 1'b0, 12'h000);
         if (c == 1) begin
            chk("first_rd", 32'(imem_rd), 1);
            chk("first_addr", 32'(imem_addr), 0);
         end
         if (c == 2) chk("second_addr", 32'(imem_addr), 1);
         if (c < FIRST) chk("pre_valid", 32'(instr_valid), 0);
         if (c >= FIRST && c <= FIRST + 2) begin
            chk("stream_valid", 32'(instr_valid), 1);
            chk("stream_pc", 32'(instr_pc), c - FIRST);
            chk("stream_instr", 32'(instr_out), 32'hA000 + c - FIRST);
         end
      end

      // Decoder stall: FIFO saturates, fetch stops
      for (int k = 0; k < 10; k++) begin
         cyc(1'b0, 1'b0, 1'b0, 12'h000);
         if (k == 9) begin
            chk("full_level", 32'(fifo_level), 4);
            chk("full_rd", 32'(imem_rd), 0);
            chk("full_valid", 32'(instr_valid), 1);
            chk("full_head_pc", 32'(instr_pc), 9 - FIRST);
         end
      end
      for (int k = 0; k < 4; k++) begin
         cyc(1'b1, 1'b0, 1'b0, 12'h000);
         if (k == 0) chk("resume_pc", 32'(instr_pc), 9 - FIRST);
         if (k == 3) begin
            chk("pre_redir_level", 32'(fifo_level), 3);
            chk("pre_redir_rd", 32'(imem_rd), 1);
         end
      end

      // Redirect with 3 buffered words and one read in flight
      cyc(1'b1, 1'b0, 1'b1, 12'h3F0);
      chk("redir_valid", 32'(instr_valid), 0);
      for (int j = 1; j <= 6; j++) begin
         cyc(1'b1, 1'b0, 1'b0, 12'h000);
         if (j == 1) begin
            chk("redir_rd", 32'(imem_rd), 1);
            chk("redir_addr", 32'(imem_addr), 32'h3F0);
            chk("redir_level", 32'(fifo_level), 0);
         end
         if (j < LATR) chk("redir_wait", 32'(instr_valid), 0);
         if (j == LATR) begin
            chk("target_valid", 32'(instr_valid), 1);
            chk("target_pc", 32'(instr_pc), 32'h3F0);
            chk("target_instr", 32'(instr_out), 32'hA3F0);
         end
         if (j == LATR + 1) chk("target_next_pc", 32'(instr_pc), 32'h3F1);
      end

      // PC wrap, then halt mid-stream and resume
      cyc(1'b1, 1'b0, 1'b1, 12'hFFE);
      for (int j = 1; j <= 18; j++) begin
         hlt = (j >= 6) && (j <= 13);
         cyc(1'b1, hlt, 1'b0, 12'h000);
         if (j == 1) begin
            chk("wrap_rd", 32'(imem_rd), 1);
            chk("wrap_addr", 32'(imem_addr), 32'hFFE);
         end
         if (j >= LATR && j < LATR + 4) begin
            chk("wrap_pc", 32'(instr_pc), 32'(wrap_pc[j - LATR]));
            chk("wrap_instr", 32'(instr_out), 32'(word_of(wrap_pc[j - LATR])));
         end
         if (j == 7) chk("halt_rd", 32'(imem_rd), 0);
         if (j == 13) begin
            chk("halt_level", 32'(fifo_level), 0);
            chk("halt_valid", 32'(instr_valid), 0);
         end
         if (j == 14) chk("unhalt_hold_rd", 32'(imem_rd), 0);
         if (j == 15) begin
            chk("unhalt_rd", 32'(imem_rd), 1);
            chk("unhalt_addr", 32'(imem_addr), 32'h004);
         end
      end

      // Reset pulse with a redirect pending
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      redirect = 1'b1;
      redirect_addr = 12'h555;
      @(negedge clk);
      chk("mid_rst_rd", 32'(imem_rd), 0);
      chk("mid_rst_valid", 32'(instr_valid), 0);
      chk("mid_rst_level", 32'(fifo_level), 0);
      chk("mid_rst_instr", 32'(instr_out), 0);
      chk("mid_rst_pc", 32'(instr_pc), 0);
      chk("mid_rst_addr", 32'(imem_addr), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      redirect = 1'b0;
      @(negedge clk);
      chk("post_rst_boot_rd", 32'(imem_rd), 0);
      for (int c = 1; c <= FIRST + 1; c++) begin
         cyc(1'b1, 1'b0, 1'b0, 12'h000);
         if (c == 1) begin
            chk("post_rst_rd", 32'(imem_rd), 1);
            chk("post_rst_addr", 32'(imem_addr), 0);
         end
         if (c == FIRST) begin
            chk("post_rst_valid", 32'(instr_valid), 1);
            chk("post_rst_pc", 32'(instr_pc), 0);
            chk("post_rst_instr", 32'(instr_out), 32'hA000);
         end
      end

      @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
